anneal_sequencer: RTL and testbench
===================================

// Module: anneal_sequencer
// PURPOSE
//  Per-iteration phase scheduler for the replica array (all or_node instances share its outputs).
//  Each iteration: random -> delta distance -> metropolis; every EX_INTERVAL-th iteration also replica test -> exchange.
//  Issues one-cycle run pulses, waits a fixed latency per phase, rotates the opt mode per iteration.
//  Counts iterations up to a programmed limit.
// PARAMETERS
//  RAND_LAT     4    cycles from random_run to K/L/r_* valid
//  DIST_LAT     8    cycles from distance_com pulse to delta_distance valid
//  METRO_LAT    6    cycles from metropolis_run to total distance updated
//  REP_LAT      6    cycles from replica_run to test result valid
//  EX_LAT       64   cycles from exchange_run to ordering exchange complete
//  OPT_NUM      2    number of opt_command_t values rotated (0..OPT_NUM-1)
//  EX_INTERVAL  4    replica exchange every N iterations, N>=1
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  start          in   1   pulse: begin run (ignored unless idle)
//  stop           in   1   pulse: finish current iteration, then stop
//  iter_limit     in   32  iterations to run; 0 = run until stop
//  opt_command    out  opt_command_t       opt mode for current iteration
//  random_run     out  1                   1-cycle pulse
//  distance_com   out  distance_command_t  DIST_RUN for 1 cycle, else DIST_NOP
//  metropolis_run out  1                   1-cycle pulse
//  replica_run    out  1                   1-cycle pulse
//  exchange_run   out  1                   1-cycle pulse
//  busy           out  1                   high from start accept to DONE
//  done           out  1                   1-cycle pulse at end of run
//  iter_count     out  32                  completed iterations
// BEHAVIOUR
//  Reset: state IDLE; all pulses 0; distance_com=DIST_NOP; opt_command=value 0; busy=0; done=0.
//  Reset: iter_count=0; stop_pend=0.
//  Reset mid-run aborts immediately; no pulse is emitted in the cycle after reset.
//  States: IDLE, RAND, W_RAND, DIST, W_DIST, METRO, W_METRO, REP, W_REP, EXCH, W_EX, DONE.
//  IDLE: start=1 -> RAND; busy=1 next cycle; iter_count=0, opt index=0, stop_pend=0 on accept.
//  Pulse states (RAND/DIST/METRO/REP/EXCH): assert own pulse exactly 1 cycle.
//  Pulse states: load wait counter with LAT-1; go to matching W_ state.
//  W_x: decrement counter; leave when counter==0, so next pulse is exactly LAT cycles after previous.
//  After W_METRO: phase = iter_count % EX_INTERVAL (== iter_count before increment).
//  If phase == EX_INTERVAL-1 -> REP, then EXCH; else go to end-of-iteration.
//  End-of-iteration (exit of W_METRO with no exchange, or exit of W_EX):
//    iter_count++; opt index = (idx==OPT_NUM-1)?0:idx+1.
//    Go to DONE if stop_pend, or if iter_limit!=0 and new count==iter_limit; else RAND.
//  DONE: done=1 for one cycle; busy=0 next cycle; -> IDLE. opt_command holds last value.
//  stop: sets stop_pend in any busy state; honoured only at end-of-iteration (never splits phases).
//  stop in IDLE: ignored.
//  start while busy: ignored.
//  start and stop same cycle in IDLE: run starts with stop_pend=1, so exactly one iteration runs.
//  opt_command: changes only at end-of-iteration; stable from RAND through W_EX.
//  iter_count: 32-bit, wraps 0xFFFFFFFF->0 when iter_limit=0; wrap does not stop the run.
//  Counters: per-phase wait counter width = $clog2(max LAT)+1; no combinational input->output paths.
// STRUCTURE
//  replica_pkg: opt_command_t and distance_command_t (DIST_NOP/DIST_RUN) plus a seq_state_t enum.
//  No sub-module: single FSM with a shared wait counter; latencies are parameters at top level.
// TESTING
//  1: start, iter_limit=1, defaults.
//     -> random_run@t0, distance_com@t0+4, metropolis_run@t0+12; no replica_run.
//     -> done at t0+18; iter_count=1.
//  2: iter_limit=4, EX_INTERVAL=4.
//     -> replica_run only in iteration 4, 6 cycles after its metropolis_run; exchange_run 6 cycles later.
//     -> done 64 cycles after exchange_run.
//  3: iter_limit=3, OPT_NUM=2 -> opt_command 0,1,0 per iteration; holds 0 after done.
//  4: iter_limit=0; stop pulse during W_DIST of iteration 2 -> iteration 2 completes; done; iter_count=2.
//  5: reset asserted in W_EX -> next cycle all pulses 0, busy=0, iter_count=0.
//     A subsequent start runs normally.
//  6: start and stop same cycle -> exactly one iteration.
//     Start pulses while busy -> no effect on timing.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types for the replica array sequencer: opt modes, distance commands
// and the phase-scheduler state encoding.
package replica_pkg;

  // Opt mode broadcast to every or_node; the sequencer rotates through the
  // first OPT_NUM encodings.
  typedef enum logic [1:0] {
    OPT_TWO   = 2'd0,
    OPT_OR    = 2'd1,
    OPT_THREE = 2'd2,
    OPT_SWAP  = 2'd3
  } opt_command_t;

  typedef enum logic {
    DIST_NOP = 1'b0,
    DIST_RUN = 1'b1
  } distance_command_t;

  typedef enum logic [3:0] {
    IDLE, RAND, W_RAND, DIST, W_DIST, METRO, W_METRO,
    REP, W_REP, EXCH, W_EX, DONE
  } seq_state_t;

  localparam int OPT_W = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/anneal_sequencer.sv
// Per-iteration phase scheduler for the replica array.
// Each iteration runs random -> delta distance -> metropolis, and every
// EX_INTERVAL-th iteration adds replica test -> exchange. Every phase is a
// one-cycle pulse followed by a fixed wait, so the next pulse lands exactly
// LAT cycles after the previous one. All latencies must be >= 2.
// All outputs decode registered state only: no input-to-output paths.
module anneal_sequencer
  import replica_pkg::*;
#(
  parameter int RAND_LAT    = 4,
  parameter int DIST_LAT    = 8,
  parameter int METRO_LAT   = 6,
  parameter int REP_LAT     = 6,
  parameter int EX_LAT      = 64,
  parameter int OPT_NUM     = 2,
  parameter int EX_INTERVAL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       iter_limit,
  output opt_command_t      opt_command,
  output logic              random_run,
  output distance_command_t distance_com,
  output logic              metropolis_run,
  output logic              replica_run,
  output logic              exchange_run,
  output logic              busy,
  output logic              done,
  output logic [31:0]       iter_count
);

  localparam int MAX_LAT = max_int(max_int(max_int(RAND_LAT, DIST_LAT),
                                           max_int(METRO_LAT, REP_LAT)),
                                   EX_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_load;
  logic [OPT_W-1:0] opt_idx;
  logic             stop_pend;
  logic             accept;
  logic             end_iter;
  logic             last_iter;
  logic             exch_phase;
  logic             wait_last;
  logic [31:0]      new_count;

  assign new_count   = iter_count + 32'd1;
  // Run ends when a stop is pending or the programmed count is reached;
  // a wrap of the counter with iter_limit == 0 never matches.
  assign last_iter   = stop_pend || ((iter_limit != 32'd0) && (new_count == iter_limit));
  // Phase uses the count before this iteration's increment.
  assign exch_phase  = (iter_count % 32'(EX_INTERVAL)) == 32'(EX_INTERVAL - 1);
  // The counter was loaded with LAT-1 on the pulse; leaving as it reaches
  // zero places the next pulse exactly LAT cycles after this one.
  assign wait_last   = (wait_cnt == CNT_W'(1));
  assign opt_command = opt_command_t'(opt_idx);
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned and infers a latch.
    state_nxt      = state;
    cnt_load       = 1'b0;
    cnt_val        = '0;
    accept         = 1'b0;
    end_iter       = 1'b0;
    random_run     = 1'b0;
    distance_com   = DIST_NOP;
    metropolis_run = 1'b0;
    replica_run    = 1'b0;
    exchange_run   = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RAND;
        end
      end
      RAND: begin
        random_run = 1'b1;
        cnt_load   = 1'b1;
        cnt_val    = CNT_W'(RAND_LAT - 1);
        state_nxt  = W_RAND;
      end
      W_RAND:  if (wait_last) state_nxt = DIST;
      DIST: begin
        distance_com = DIST_RUN;
        cnt_load     = 1'b1;
        cnt_val      = CNT_W'(DIST_LAT - 1);
        state_nxt    = W_DIST;
      end
      W_DIST:  if (wait_last) state_nxt = METRO;
      METRO: begin
        metropolis_run = 1'b1;
        cnt_load       = 1'b1;
        cnt_val        = CNT_W'(METRO_LAT - 1);
        state_nxt      = W_METRO;
      end
      W_METRO: begin
        if (wait_last) begin
          if (exch_phase) begin
            state_nxt = REP;
          end else begin
            end_iter  = 1'b1;
            state_nxt = last_iter ? DONE : RAND;
          end
        end
      end
      REP: begin
        replica_run = 1'b1;
        cnt_load    = 1'b1;
        cnt_val     = CNT_W'(REP_LAT - 1);
        state_nxt   = W_REP;
      end
      W_REP:   if (wait_last) state_nxt = EXCH;
      EXCH: begin
        exchange_run = 1'b1;
        cnt_load     = 1'b1;
        cnt_val      = CNT_W'(EX_LAT - 1);
        state_nxt    = W_EX;
      end
      W_EX: begin
        if (wait_last) begin
          end_iter  = 1'b1;
          state_nxt = last_iter ? DONE : RAND;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter, iteration count, opt rotation and stop latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      iter_count <= '0;
      opt_idx    <= '0;
      stop_pend  <= 1'b0;
    end else begin
      if (cnt_load)            wait_cnt <= cnt_val;
      else if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);

      if (accept) begin
        iter_count <= '0;
        opt_idx    <= '0;
        // A stop arriving with start makes this a single-iteration run.
        stop_pend  <= stop;
      end else begin
        if (busy && stop) stop_pend <= 1'b1;
        if (end_iter) begin
          iter_count <= new_count;
          // The final iteration's opt mode is held through DONE and IDLE.
          if (!last_iter)
            opt_idx <= (opt_idx == OPT_W'(OPT_NUM - 1)) ? '0 : opt_idx + OPT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_anneal_sequencer.sv
// Scoreboard bench for anneal_sequencer: the stimulus thread pushes the
// expected pulse/done events with their cycle numbers, and a monitor pops
// and compares whenever the DUT presents one.
module tb_anneal_sequencer;
  import replica_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [31:0]       iter_limit = 32'd0;
  opt_command_t      opt_command;
  logic              random_run;
  distance_command_t distance_com;
  logic              metropolis_run;
  logic              replica_run;
  logic              exchange_run;
  logic              busy;
  logic              done;
  logic [31:0]       iter_count;

  anneal_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .iter_limit     (iter_limit),
    .opt_command    (opt_command),
    .random_run     (random_run),
    .distance_com   (distance_com),
    .metropolis_run (metropolis_run),
    .replica_run    (replica_run),
    .exchange_run   (exchange_run),
    .busy           (busy),
    .done           (done),
    .iter_count     (iter_count)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_RAND, EV_DIST, EV_METRO, EV_REP, EV_EXCH, EV_DONE} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
    int  opt;
    int  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_ev(input ev_e k, input int c, input int o, input int n);
    exp_t e;
    e.kind = k; e.cyc = c; e.opt = o; e.cnt = n;
    exp_q.push_back(e);
  endfunction

  // Hand-derived default timing: DIST +4, METRO +12, REP +18, EXCH +24,
  // iteration end +18 without exchange, +88 with.
  task automatic push_iter(input int t, input int o, input bit exch, output int t_end);
    push_ev(EV_RAND,  t,      o, 0);
    push_ev(EV_DIST,  t + 4,  o, 0);
    push_ev(EV_METRO, t + 12, o, 0);
    if (exch) begin
      push_ev(EV_REP,  t + 18, o, 0);
      push_ev(EV_EXCH, t + 24, o, 0);
      t_end = t + 88;
    end else begin
      t_end = t + 18;
    end
  endtask

  // Monitor: compare each presented event against the scoreboard head.
  always @(negedge clk) begin : monitor
    int   n;
    ev_e  k;
    exp_t e;
    if (mon_en) begin
      n = int'(random_run) + int'(distance_com == DIST_RUN) + int'(metropolis_run)
        + int'(replica_run) + int'(exchange_run) + int'(done);
      k = random_run ? EV_RAND : (distance_com == DIST_RUN) ? EV_DIST :
          metropolis_run ? EV_METRO : replica_run ? EV_REP :
          exchange_run ? EV_EXCH : EV_DONE;
      if (n > 1) begin
        check("single_event", n, 1);
      end else if (n == 1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind",  k, e.kind);
          check("event_cycle", cyc, e.cyc);
          check("event_opt",   opt_command, e.opt);
          check("event_busy",  busy, 1);
          if (k == EV_DONE) check("done_iter_count", iter_count, e.cnt);
        end
      end
    end
  end

  // Called from a point #1 after a rising edge.
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [31:0] lim, input bit with_stop, output int t0);
    @(posedge clk);
    #1;
    iter_limit = lim;
    start      = 1'b1;
    stop       = with_stop;
    t0         = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < budget);
    if (done !== 1'b1) check({name, "_done_timeout"}, 0, 1);
    @(negedge clk);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_missing_events"}, exp_q.size(), 0);
  endtask

  task automatic check_quiet(input string name, input int cnt, input int opt);
    check({name, "_busy"},    busy, 0);
    check({name, "_done"},    done, 0);
    check({name, "_pulses"},  {random_run, metropolis_run, replica_run, exchange_run}, 0);
    check({name, "_dist"},    distance_com, DIST_NOP);
    check({name, "_count"},   iter_count, cnt);
    check({name, "_opt"},     opt_command, opt);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    int t0, t, te;

    // Reset state.
    repeat (3) @(negedge clk);
    check_quiet("reset", 0, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // 1: single iteration.
    start_run(32'd1, 1'b0, t0);
    push_iter(t0, 0, 1'b0, te);
    push_ev(EV_DONE, te, 0, 1);
    wait_done("t1", 100);
    check("t1_count_hold", iter_count, 1);

    // 2: four iterations, exchange only in the fourth.
    start_run(32'd4, 1'b0, t0);
    t = t0;
    for (int i = 0; i < 4; i++) begin
      push_iter(t, i % 2, i == 3, te);
      t = te;
    end
    push_ev(EV_DONE, t, 1, 4);
    wait_done("t2", 250);

    // 3: opt rotation 0,1,0 and hold after done.
    start_run(32'd3, 1'b0, t0);
    push_iter(t0,      0, 1'b0, te);
    push_iter(t0 + 18, 1, 1'b0, te);
    push_iter(t0 + 36, 0, 1'b0, te);
    push_ev(EV_DONE, t0 + 54, 0, 3);
    wait_done("t3", 150);
    check("t3_opt_hold", opt_command, 0);

    // 4: unlimited run, stop in W_DIST of iteration 2.
    start_run(32'd0, 1'b0, t0);
    push_iter(t0,      0, 1'b0, te);
    push_iter(t0 + 18, 1, 1'b0, te);
    push_ev(EV_DONE, t0 + 36, 1, 2);
    wait_cyc(t0 + 25);
    stop = 1'b1;
    wait_cyc(t0 + 26);
    stop = 1'b0;
    wait_done("t4", 150);
    check("t4_count", iter_count, 2);

    // 5: reset during W_EX of iteration 4 aborts the run.
    start_run(32'd4, 1'b0, t0);
    t = t0;
    for (int i = 0; i < 4; i++) begin
      push_iter(t, i % 2, i == 3, te);
      t = te;
    end
    wait_cyc(t0 + 54 + 40);
    reset = 1'b1;
    wait_cyc(t0 + 54 + 41);
    @(negedge clk);
    check_quiet("t5_after_reset", 0, 0);
    check("t5_pre_reset_events", exp_q.size(), 0);
    reset = 1'b0;
    start_run(32'd1, 1'b0, t0);
    push_iter(t0, 0, 1'b0, te);
    push_ev(EV_DONE, te, 0, 1);
    wait_done("t5_restart", 100);

    // 6a: start and stop together -> exactly one iteration.
    start_run(32'd0, 1'b1, t0);
    push_iter(t0, 0, 1'b0, te);
    push_ev(EV_DONE, te, 0, 1);
    wait_done("t6a", 100);

    // 6b: stop in idle ignored; start pulses while busy ignored.
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    start_run(32'd2, 1'b0, t0);
    push_iter(t0,      0, 1'b0, te);
    push_iter(t0 + 18, 1, 1'b0, te);
    push_ev(EV_DONE, t0 + 36, 1, 2);
    wait_cyc(t0 + 5);  start = 1'b1;
    wait_cyc(t0 + 6);  start = 1'b0;
    wait_cyc(t0 + 30); start = 1'b1;
    wait_cyc(t0 + 31); start = 1'b0;
    wait_done("t6b", 100);
    check("t6b_count", iter_count, 2);

    repeat (3) @(negedge clk);
    check("final_no_stray_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
